// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1-style serial receiver, LSB first, AXI-stream word output
//             with single-cycle overrun / framing error pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] output_axi_tdata,
    output logic                  output_axi_tvalid,
    input  logic                  output_axi_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic                  r_sync1;
    logic                  r_rxd_s;
    logic [2:0]            r_state;
    logic [18:0]           r_cnt;
    logic [18:0]           r_period_m1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_BIT_W-1:0]    r_bit_idx;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_overrun;
    logic                  r_frame_err;

    logic [2:0]            w_state_next;
    logic [18:0]           w_cnt_next;
    logic [18:0]           w_period_m1_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [c_BIT_W-1:0]    w_bit_next;
    logic                  w_word_done;
    logic                  w_frame_err;
    logic                  w_tick;
    logic [15:0]           w_ps_eff;
    logic [DATA_WIDTH:0]   w_cat;

    assign w_ps_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_tick   = (r_cnt == 19'd0);
    assign w_cat    = {r_rxd_s, r_shift};

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = w_tick ? r_cnt : r_cnt - 19'd1;
        w_period_m1_next = r_period_m1;
        w_shift_next     = r_shift;
        w_bit_next       = r_bit_idx;
        w_word_done      = 1'b0;
        w_frame_err      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!r_rxd_s) begin
                    // Counter expires on the start-bit centre, half a bit after the edge.
                    w_state_next     = c_START;
                    w_cnt_next       = {1'b0, w_ps_eff, 2'b00} - 19'd1;
                    w_period_m1_next = {w_ps_eff, 3'b000} - 19'd1;
                end
            end
            c_START: begin
                if (w_tick) begin
                    if (r_rxd_s) begin
                        w_state_next = c_IDLE;
                    end else begin
                        w_state_next = c_DATA;
                        w_cnt_next   = r_period_m1;
                        w_bit_next   = '0;
                    end
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    w_shift_next = w_cat[DATA_WIDTH:1];
                    w_cnt_next   = r_period_m1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = c_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + c_BIT_W'(1);
                    end
                end
            end
            c_STOP: begin
                if (w_tick) begin
                    if (r_rxd_s) begin
                        w_word_done  = 1'b1;
                        w_state_next = c_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = c_WAIT_HIGH;
                    end
                end
            end
            c_WAIT_HIGH: begin
                if (r_rxd_s) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_rxd_s     <= 1'b1;
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_period_m1 <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_rxd_s     <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_period_m1 <= w_period_m1_next;
            r_shift     <= w_shift_next;
            r_bit_idx   <= w_bit_next;
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_word_done) begin
                // A word accepted this same cycle frees the slot, so no overrun.
                r_tdata   <= r_shift;
                r_tvalid  <= 1'b1;
                r_overrun <= r_tvalid & ~output_axi_tready;
            end else if (r_tvalid && output_axi_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign output_axi_tdata  = r_tdata;
    assign output_axi_tvalid = r_tvalid;
    assign busy              = (r_state != c_IDLE);
    assign overrun_error     = r_overrun;
    assign frame_error       = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        rxd;
    logic        busy;
    logic        ovr;
    logic        fe;
    logic [15:0] prescale;

    int          n_vec;
    int          n_fail;
    int          cyc;

    logic [7:0]  got[$];
    int          n_valid_cyc;
    int          n_busy_cyc;
    int          n_ovr;
    int          n_fe;
    int          valid_rise;
    int          busy_rise;
    int          busy_last;
    logic        prev_valid;
    logic        prev_busy;
    int          t_start;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .output_axi_tdata  (tdata),
        .output_axi_tvalid (tvalid),
        .output_axi_tready (tready),
        .rxd               (rxd),
        .busy              (busy),
        .overrun_error     (ovr),
        .frame_error       (fe),
        .prescale          (prescale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid && tready) got.push_back(tdata);
        if (tvalid) n_valid_cyc++;
        if (tvalid && !prev_valid) valid_rise = cyc;
        if (ovr) n_ovr++;
        if (fe) n_fe++;
        if (busy) begin
            n_busy_cyc++;
            if (!prev_busy) busy_rise = cyc;
            busy_last = cyc;
        end
        prev_valid = tvalid;
        prev_busy  = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got.delete();
        n_valid_cyc = 0;
        n_busy_cyc  = 0;
        n_ovr       = 0;
        n_fe        = 0;
        valid_rise  = -1;
        busy_rise   = -1;
        busy_last   = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits[0] is the start bit, bits[9] the stop bit; each held p clocks
    task automatic send(input logic [7:0] d, input logic stop_bit, input int p);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (p) tick();
        end
    endtask

    initial begin
        n_vec = 0; n_fail = 0; cyc = 0;
        prev_valid = 1'b0; prev_busy = 1'b0;
        clr();
        rst = 1'b1; rxd = 1'b1; tready = 1'b1; prescale = 16'd1;
        repeat (3) tick();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, ovr, fe}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // single frame, latency and busy window
        clr();
        send(8'h5A, 1'b1, 8);
        repeat (4) tick();
        chk("t1_count", got.size(), 32'd1);
        chk("t1_data", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'h5A);
        chk("t1_valid_cyc", n_valid_cyc, 32'd1);
        chk("t1_latency", valid_rise - t_start, 32'd79);
        chk("t1_busy_rise", busy_rise - t_start, 32'd3);
        chk("t1_busy_last", busy_last - t_start, 32'd78);
        chk("t1_errs", n_ovr + n_fe, 32'd0);

        // back-to-back frames
        clr();
        send(8'h00, 1'b1, 8);
        send(8'hFF, 1'b1, 8);
        send(8'h81, 1'b1, 8);
        repeat (4) tick();
        chk("t2_count", got.size(), 32'd3);
        chk("t2_w0", (got.size() > 2) ? {24'd0, got[0]} : 32'hDEAD, 32'h00);
        chk("t2_w1", (got.size() > 2) ? {24'd0, got[1]} : 32'hDEAD, 32'hFF);
        chk("t2_w2", (got.size() > 2) ? {24'd0, got[2]} : 32'hDEAD, 32'h81);
        chk("t2_valid_cyc", n_valid_cyc, 32'd3);
        chk("t2_errs", n_ovr + n_fe, 32'd0);

        // overrun
        clr();
        tready = 1'b0;
        send(8'h11, 1'b1, 8);
        send(8'h22, 1'b1, 8);
        repeat (4) tick();
        chk("t3_ovr", n_ovr, 32'd1);
        chk("t3_tdata", {24'd0, tdata}, 32'h22);
        chk("t3_tvalid", {31'd0, tvalid}, 32'd1);
        chk("t3_none_taken", got.size(), 32'd0);
        tready = 1'b1;
        repeat (3) tick();
        chk("t3_count", got.size(), 32'd1);
        chk("t3_data", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'h22);
        chk("t3_tvalid_clr", {31'd0, tvalid}, 32'd0);

        // framing error, stuck-low line, then recovery
        clr();
        send(8'h33, 1'b0, 8);
        repeat (20) tick();
        chk("t4_busy_held", {31'd0, busy}, 32'd1);
        t_start = cyc;
        rxd = 1'b1;
        repeat (6) tick();
        chk("t4_fe", n_fe, 32'd1);
        chk("t4_no_valid", n_valid_cyc, 32'd0);
        chk("t4_busy_last", busy_last - t_start, 32'd2);
        send(8'h44, 1'b1, 8);
        repeat (4) tick();
        chk("t4_count", got.size(), 32'd1);
        chk("t4_data", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'h44);
        chk("t4_fe_total", n_fe, 32'd1);

        // start-bit glitch at prescale=4 (H=16)
        clr();
        prescale = 16'd4;
        t_start = cyc;
        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (40) tick();
        chk("t5_no_valid", n_valid_cyc, 32'd0);
        chk("t5_errs", n_ovr + n_fe, 32'd0);
        chk("t5_busy_cyc", n_busy_cyc, 32'd16);
        chk("t5_busy_rise", busy_rise - t_start, 32'd3);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // reset during data bit 3 of 0xA5
        clr();
        prescale = 16'd1;
        rxd = 1'b0; repeat (8) tick();
        rxd = 1'b1; repeat (8) tick();
        rxd = 1'b0; repeat (8) tick();
        rxd = 1'b1; repeat (8) tick();
        rxd = 1'b0; repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("t6_rst_tdata", {24'd0, tdata}, 32'd0);
        chk("t6_rst_errs", {30'd0, ovr, fe}, 32'd0);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (4) tick();
        clr();
        send(8'h3C, 1'b1, 8);
        repeat (4) tick();
        chk("t6_count", got.size(), 32'd1);
        chk("t6_data", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'h3C);
        chk("t6_errs", n_ovr + n_fe, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
